// File: rtl/board_lock_clear.sv
// -----------------------------------------------------------------------------
// board_lock_clear
//
// Consumer end of the piece-lock handshake. A lock_en pulse captures the four
// square coordinates of the falling piece and ORs them into the ROWS x COLS
// playfield. The block then scans bottom-up for full rows, clears each one by
// shifting everything above it down, and reports the result.
//
// Ports
//   pclk          : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   lock_en       : 1-cycle pulse, lock the four squares below into the board
//   sq_N_col/row  : coordinates of piece square N (1..4), valid with lock_en
//   rd_row        : renderer / collision read row select
//   rd_data       : board[rd_row], combinational, 0 when rd_row >= ROWS
//   busy          : high in every state except IDLE
//   done          : 1-cycle pulse when the lock/clear sequence finishes
//   lines_cleared : rows cleared by the last lock, held until the next done
//   total_lines   : running sum of cleared rows, saturating at 16'hFFFF
//   game_over     : sticky, row 0 non-empty after a lock
// -----------------------------------------------------------------------------
module board_lock_clear #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int COL_W = 4,
    parameter int ROW_W = 5
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             lock_en,
    input  logic [COL_W-1:0] sq_1_col,
    input  logic [COL_W-1:0] sq_2_col,
    input  logic [COL_W-1:0] sq_3_col,
    input  logic [COL_W-1:0] sq_4_col,
    input  logic [ROW_W-1:0] sq_1_row,
    input  logic [ROW_W-1:0] sq_2_row,
    input  logic [ROW_W-1:0] sq_3_row,
    input  logic [ROW_W-1:0] sq_4_row,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data,
    output logic             busy,
    output logic             done,
    output logic [2:0]       lines_cleared,
    output logic [15:0]      total_lines,
    output logic             game_over
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [COLS-1:0]  board      [ROWS];
    logic [COLS-1:0]  write_mask [ROWS];
    logic [COL_W-1:0] cap_col    [4];
    logic [ROW_W-1:0] cap_row    [4];
    logic [ROW_W-1:0] scan_row;
    logic [2:0]       clr_cnt;
    logic             row_full;
    logic [ROWS-1:1]  shift_sel;
    logic [16:0]      total_sum;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:    if (lock_en) state_nxt = WRITE;
            WRITE:   state_nxt = SCAN;
            SCAN: begin
                if (row_full) begin
                    state_nxt = SHIFT;
                end else if (scan_row == '0) begin
                    state_nxt = DONE;
                end
            end
            SHIFT:   state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinates are only accepted in IDLE, so a lock_en while busy is dropped.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) begin
                cap_col[s] <= '0;
                cap_row[s] <= '0;
            end
        end else if (state == IDLE && lock_en) begin
            cap_col[0] <= sq_1_col;
            cap_col[1] <= sq_2_col;
            cap_col[2] <= sq_3_col;
            cap_col[3] <= sq_4_col;
            cap_row[0] <= sq_1_row;
            cap_row[1] <= sq_2_row;
            cap_row[2] <= sq_3_row;
            cap_row[3] <= sq_4_row;
        end
    end

    // scan_row stays put across a SHIFT so the row that just dropped into it
    // is re-checked; this is what catches stacked full rows.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            scan_row <= '0;
            clr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_en) begin
                        scan_row <= ROW_W'(ROWS - 1);
                        clr_cnt  <= '0;
                    end
                end
                SCAN: begin
                    if (!row_full && scan_row != '0) begin
                        scan_row <= scan_row - ROW_W'(1);
                    end
                end
                SHIFT: begin
                    if (clr_cnt != 3'd7) begin
                        clr_cnt <= clr_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only exact coordinate matches set a cell, so out-of-range squares
    // never alias onto a real cell.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            write_mask[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                for (int s = 0; s < 4; s++) begin
                    if (cap_row[s] == ROW_W'(r) && cap_col[s] == COL_W'(c)) begin
                        write_mask[r][c] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        row_full = (board[scan_row] == {COLS{1'b1}});
        for (int r = 1; r < ROWS; r++) begin
            shift_sel[r] = (ROW_W'(r) <= scan_row);
        end
    end

    // Rows below the cleared row are left alone; rows at or above it move down one.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                board[r] <= '0;
            end
        end else if (state == WRITE) begin
            for (int r = 0; r < ROWS; r++) begin
                board[r] <= board[r] | write_mask[r];
            end
        end else if (state == SHIFT) begin
            board[0] <= '0;
            for (int r = 1; r < ROWS; r++) begin
                if (shift_sel[r]) begin
                    board[r] <= board[r-1];
                end
            end
        end
    end

    always_comb begin
        total_sum = {1'b0, total_lines} + {14'd0, clr_cnt};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lines_cleared <= '0;
            total_lines   <= '0;
            game_over     <= 1'b0;
        end else if (state == DONE) begin
            lines_cleared <= clr_cnt;
            total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            game_over     <= game_over | (|board[0]);
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_row < ROW_W'(ROWS)) begin
            rd_data = board[rd_row];
        end
    end

endmodule
